// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control FSM: state encoding,
// opcodes, datapath mux codes and the bundled control-output record.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    JAL,
    JALR,
    LUI,
    TRAP
  } state_e;

  typedef logic [1:0] sel_t;
  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_LOAD   = 7'b0000011;
  localparam opcode_t OP_STORE  = 7'b0100011;
  localparam opcode_t OP_R      = 7'b0110011;
  localparam opcode_t OP_I      = 7'b0010011;
  localparam opcode_t OP_BRANCH = 7'b1100011;
  localparam opcode_t OP_JAL    = 7'b1101111;
  localparam opcode_t OP_JALR   = 7'b1100111;
  localparam opcode_t OP_LUI    = 7'b0110111;

  localparam sel_t SRCA_PC     = 2'b00;
  localparam sel_t SRCA_OLDPC  = 2'b01;
  localparam sel_t SRCA_RS1    = 2'b10;

  localparam sel_t SRCB_RS2    = 2'b00;
  localparam sel_t SRCB_IMM    = 2'b01;
  localparam sel_t SRCB_FOUR   = 2'b10;

  localparam sel_t ALUOP_ADD   = 2'b00;
  localparam sel_t ALUOP_SUB   = 2'b01;
  localparam sel_t ALUOP_FUNCT = 2'b10;

  localparam sel_t RES_ALUOUT  = 2'b00;
  localparam sel_t RES_MEMDATA = 2'b01;
  localparam sel_t RES_ALU     = 2'b10;
  localparam sel_t RES_IMM     = 2'b11;

  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic ir_write;
    logic pc_write;
    logic reg_write;
    sel_t alu_src_a;
    sel_t alu_src_b;
    sel_t alu_op;
    sel_t result_src;
    logic trap;
  } ctrl_out_t;

  // Dispatch target after DECODE; unsupported opcodes go to the sticky TRAP state.
  function automatic state_e decode_next(input opcode_t opcode);
    state_e nxt;
    case (opcode)
      OP_LOAD, OP_STORE: nxt = MEMADR;
      OP_R:              nxt = EXECR;
      OP_I:              nxt = EXECI;
      OP_BRANCH:         nxt = BRANCH;
      OP_JAL:            nxt = JAL;
      OP_JALR:           nxt = JALR;
      OP_LUI:            nxt = LUI;
      default:           nxt = TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/handshake bundle between the multicycle controller (master) and
// the datapath plus shared memory (slave).
interface multicycle_ctrl_fsm_if;
  import ctrl_pkg::*;

  opcode_t opcode;
  logic    branch_taken;
  logic    mem_ready;

  logic    mem_req;
  logic    mem_we;
  logic    adr_src;
  logic    ir_write;
  logic    pc_write;
  logic    reg_write;
  sel_t    alu_src_a;
  sel_t    alu_src_b;
  sel_t    alu_op;
  sel_t    result_src;
  logic    trap;

  modport master (
    input  opcode,
    input  branch_taken,
    input  mem_ready,
    output mem_req,
    output mem_we,
    output adr_src,
    output ir_write,
    output pc_write,
    output reg_write,
    output alu_src_a,
    output alu_src_b,
    output alu_op,
    output result_src,
    output trap
  );

  modport slave (
    output opcode,
    output branch_taken,
    output mem_ready,
    input  mem_req,
    input  mem_we,
    input  adr_src,
    input  ir_write,
    input  pc_write,
    input  reg_write,
    input  alu_src_a,
    input  alu_src_b,
    input  alu_op,
    input  result_src,
    input  trap
  );

endinterface

// File: rtl/ctrl_out_decode.sv
// Purely combinational output decode for the multicycle controller: maps the
// current state (plus mem_ready / branch_taken Mealy terms) to datapath controls.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_e    state,
  input  logic      rst,
  input  logic      mem_ready,
  input  logic      branch_taken,
  output ctrl_out_t ctrl
);

  // Reset is active-low; while held, every control is forced inactive so an
  // aborted instruction can never leave a partial write enable behind.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      case (state)
        FETCH: begin
          ctrl.mem_req    = 1'b1;
          ctrl.adr_src    = 1'b0;
          ctrl.alu_src_a  = SRCA_PC;
          ctrl.alu_src_b  = SRCB_FOUR;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.result_src = RES_ALU;
          ctrl.ir_write   = mem_ready;
          ctrl.pc_write   = mem_ready;
        end
        DECODE: begin
          ctrl.alu_src_a = SRCA_OLDPC;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        MEMADR: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        MEMREAD: begin
          ctrl.mem_req = 1'b1;
          ctrl.adr_src = 1'b1;
        end
        MEMWB: begin
          ctrl.result_src = RES_MEMDATA;
          ctrl.reg_write  = 1'b1;
        end
        MEMWRITE: begin
          ctrl.mem_req = 1'b1;
          ctrl.mem_we  = 1'b1;
          ctrl.adr_src = 1'b1;
        end
        EXECR: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_RS2;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        EXECI: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        ALUWB: begin
          ctrl.result_src = RES_ALUOUT;
          ctrl.reg_write  = 1'b1;
        end
        // Branch target was latched into ALUOut during DECODE; the compare
        // runs now and steers the PC write directly.
        BRANCH: begin
          ctrl.alu_src_a  = SRCA_RS1;
          ctrl.alu_src_b  = SRCB_RS2;
          ctrl.alu_op     = ALUOP_SUB;
          ctrl.result_src = RES_ALUOUT;
          ctrl.pc_write   = branch_taken;
        end
        JALR: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        JAL: begin
          ctrl.alu_src_a  = SRCA_OLDPC;
          ctrl.alu_src_b  = SRCB_FOUR;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.result_src = RES_ALUOUT;
          ctrl.pc_write   = 1'b1;
        end
        LUI: begin
          ctrl.result_src = RES_IMM;
          ctrl.reg_write  = 1'b1;
        end
        TRAP: begin
          ctrl.trap = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: state register and next-state
// logic here, output decode in ctrl_out_decode.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_fsm_if.master bus
);

  state_e    state_q;
  state_e    state_d;
  ctrl_out_t ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory states hold until mem_ready; TRAP is absorbing until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE:   state_d = decode_next(bus.opcode);
      MEMADR:   state_d = bus.opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (bus.mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JALR:     state_d = JAL;
      JAL:      state_d = ALUWB;
      LUI:      state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  ctrl_out_decode u_out_decode (
    .state        (state_q),
    .rst          (rst),
    .mem_ready    (bus.mem_ready),
    .branch_taken (bus.branch_taken),
    .ctrl         (ctrl)
  );

  assign bus.mem_req    = ctrl.mem_req;
  assign bus.mem_we     = ctrl.mem_we;
  assign bus.adr_src    = ctrl.adr_src;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.pc_write   = ctrl.pc_write;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.result_src = ctrl.result_src;
  assign bus.trap       = ctrl.trap;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: each instruction is expanded into its list
// of phases from the opcode, and the expected controls are checked per cycle.
module tb_multicycle_ctrl_fsm;

  localparam int PH_FETCH    = 0;
  localparam int PH_DECODE   = 1;
  localparam int PH_MEMADR   = 2;
  localparam int PH_MEMREAD  = 3;
  localparam int PH_MEMWB    = 4;
  localparam int PH_MEMWRITE = 5;
  localparam int PH_EXECR    = 6;
  localparam int PH_EXECI    = 7;
  localparam int PH_ALUWB    = 8;
  localparam int PH_BRANCH   = 9;
  localparam int PH_JAL      = 10;
  localparam int PH_JALR     = 11;
  localparam int PH_LUI      = 12;
  localparam int PH_TRAP     = 13;

  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_R      = 7'b0110011;
  localparam logic [6:0] C_I      = 7'b0010011;
  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_LUI    = 7'b0110111;

  // {trap, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, a, b, op, rs}
  // Reset only guarantees enables, request and trap, so mux selects are masked.
  localparam logic [14:0] RST_MASK = 15'b111_0111_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   instrCount = 0;
  int   plan[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic bit coin();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  function automatic logic [14:0] observed();
    return {bus.trap, bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write,
            bus.pc_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.result_src};
  endfunction

  function automatic string phaseName(input int ph);
    case (ph)
      PH_FETCH:    return "FETCH";
      PH_DECODE:   return "DECODE";
      PH_MEMADR:   return "MEMADR";
      PH_MEMREAD:  return "MEMREAD";
      PH_MEMWB:    return "MEMWB";
      PH_MEMWRITE: return "MEMWRITE";
      PH_EXECR:    return "EXECR";
      PH_EXECI:    return "EXECI";
      PH_ALUWB:    return "ALUWB";
      PH_BRANCH:   return "BRANCH";
      PH_JAL:      return "JAL";
      PH_JALR:     return "JALR";
      PH_LUI:      return "LUI";
      default:     return "TRAP";
    endcase
  endfunction

  // Control values each phase must present, written from the state table.
  function automatic logic [14:0] expOut(input int ph, input bit ready, input bit taken);
    logic trap, req, we, adr, ir, pc, rw;
    logic [1:0] a, b, op, rs;
    {trap, req, we, adr, ir, pc, rw} = 7'b0;
    a = 2'b00; b = 2'b00; op = 2'b00; rs = 2'b00;
    case (ph)
      PH_FETCH:    begin req = 1'b1; b = 2'b10; rs = 2'b10; ir = ready; pc = ready; end
      PH_DECODE:   begin a = 2'b01; b = 2'b01; end
      PH_MEMADR:   begin a = 2'b10; b = 2'b01; end
      PH_MEMREAD:  begin req = 1'b1; adr = 1'b1; end
      PH_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      PH_MEMWRITE: begin req = 1'b1; we = 1'b1; adr = 1'b1; end
      PH_EXECR:    begin a = 2'b10; b = 2'b00; op = 2'b10; end
      PH_EXECI:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
      PH_ALUWB:    begin rw = 1'b1; end
      PH_BRANCH:   begin a = 2'b10; op = 2'b01; pc = taken; end
      PH_JAL:      begin a = 2'b01; b = 2'b10; pc = 1'b1; end
      PH_JALR:     begin a = 2'b10; b = 2'b01; end
      PH_LUI:      begin rs = 2'b11; rw = 1'b1; end
      default:     begin trap = 1'b1; end
    endcase
    return {trap, req, we, adr, ir, pc, rw, a, b, op, rs};
  endfunction

  task automatic planPhases(input logic [6:0] op);
    plan.delete();
    plan.push_back(PH_FETCH);
    plan.push_back(PH_DECODE);
    case (op)
      C_LOAD:   begin plan.push_back(PH_MEMADR); plan.push_back(PH_MEMREAD); plan.push_back(PH_MEMWB); end
      C_STORE:  begin plan.push_back(PH_MEMADR); plan.push_back(PH_MEMWRITE); end
      C_R:      begin plan.push_back(PH_EXECR); plan.push_back(PH_ALUWB); end
      C_I:      begin plan.push_back(PH_EXECI); plan.push_back(PH_ALUWB); end
      C_BRANCH: plan.push_back(PH_BRANCH);
      C_JAL:    begin plan.push_back(PH_JAL); plan.push_back(PH_ALUWB); end
      C_JALR:   begin plan.push_back(PH_JALR); plan.push_back(PH_JAL); plan.push_back(PH_ALUWB); end
      C_LUI:    plan.push_back(PH_LUI);
      default:  plan.push_back(PH_TRAP);
    endcase
  endtask

  task automatic applyStimulus(input bit ready, input bit taken);
    bus.mem_ready    = ready;
    bus.branch_taken = taken;
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called one time unit after a rising edge; leaves at the same point of the next cycle.
  task automatic stepPhase(input int ph, input bit ready, input bit taken);
    applyStimulus(ready, taken);
    #1;
    checkOutput($sformatf("%s#%0d", phaseName(ph), instrCount), observed(), expOut(ph, ready, taken));
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [6:0] op, input bit taken, input int fetchWaits, input int memWaits);
    int ph;
    instrCount++;
    bus.opcode = op;
    planPhases(op);
    for (int i = 0; i < plan.size(); i++) begin
      ph = plan[i];
      if (ph == PH_FETCH || ph == PH_MEMREAD || ph == PH_MEMWRITE) begin
        repeat ((ph == PH_FETCH) ? fetchWaits : memWaits) stepPhase(ph, 1'b0, coin());
        stepPhase(ph, 1'b1, coin());
      end else if (ph == PH_BRANCH) begin
        stepPhase(ph, coin(), taken);
      end else if (ph == PH_TRAP) begin
        repeat (20) stepPhase(ph, coin(), coin());
      end else begin
        stepPhase(ph, coin(), coin());
      end
    end
  endtask

  initial begin
    logic [6:0] legal [9];
    legal = '{C_LOAD, C_STORE, C_R, C_I, C_BRANCH, C_JAL, C_JALR, C_LUI, C_BRANCH};

    bus.opcode = C_R;
    applyStimulus(1'b1, 1'b1);
    #2;
    checkOutput("reset_async", observed() & RST_MASK, 15'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", observed() & RST_MASK, 15'd0);
    rst = 1'b1;

    runInstr(C_R, 1'b0, 0, 0);
    runInstr(C_LOAD, 1'b0, 2, 1);
    runInstr(C_BRANCH, 1'b1, 0, 0);
    runInstr(C_BRANCH, 1'b0, 0, 0);
    runInstr(C_JALR, 1'b0, 0, 0);
    runInstr(C_STORE, 1'b0, 1, 2);
    runInstr(C_I, 1'b0, 0, 0);
    runInstr(C_JAL, 1'b0, 1, 0);
    runInstr(C_LUI, 1'b0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      runInstr(legal[$urandom_range(0, 8)], coin(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while a store is stalled waiting on memory.
    instrCount++;
    bus.opcode = C_STORE;
    stepPhase(PH_FETCH, 1'b1, 1'b0);
    stepPhase(PH_DECODE, 1'b0, 1'b0);
    stepPhase(PH_MEMADR, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    #1;
    checkOutput("memwrite_stall", observed(), expOut(PH_MEMWRITE, 1'b0, 1'b0));
    #1;
    rst = 1'b0;
    #1;
    checkOutput("memwrite_abort", observed() & RST_MASK, 15'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("restart_fetch", observed(), expOut(PH_FETCH, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    runInstr(C_R, 1'b0, 0, 0);

    runInstr(7'b0000000, 1'b0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("trap_reset", observed() & RST_MASK, 15'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #1;
    checkOutput("trap_cleared", observed(), expOut(PH_FETCH, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    runInstr(C_LUI, 1'b0, 0, 0);
    runInstr(C_LOAD, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control state machine for the multicycle RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the enable of the instruction/old-PC register pair, the PC and register-file write strobes, datapath mux selects, and the request/ready handshake to the shared instruction/data memory. Unsupported opcodes stop the core in a sticky trap.

## Interface
Parameters: none. State encoding, opcodes and mux codes come from the shared package.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- branch_taken  in  1  branch condition from the ALU compare unit, already qualified by funct3
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  enable for the instruction/old-PC register pair
- pc_write  out  1  PC register enable
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  ALU A input: 00 = PC, 01 = oldPC, 10 = rs1 register
- alu_src_b  out  2  ALU B input: 00 = rs2 register, 01 = immediate, 10 = constant 4
- alu_op  out  2  ALU operation: 00 = add, 01 = subtract/compare, 10 = decoded from funct3/funct7
- result_src  out  2  result bus: 00 = ALUOut, 01 = memory data register, 10 = live ALU result, 11 = immediate
- trap  out  1  illegal-opcode flag, sticky

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
- Outputs not listed for a state are 0 / 00.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - While mem_ready=0: stay in FETCH; ir_write=0, pc_write=0.
  - On mem_ready=1: ir_write=1, pc_write=1 (PC+4), go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (oldPC+imm latched to ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - any other opcode → TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: MEMREAD if opcode[5]=0, MEMWRITE if opcode[5]=1.
- MEMREAD: mem_req=1, adr_src=1. Stay until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Stay until mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=branch_taken (Mealy output), then FETCH.
- JALR: alu_src_a=10, alu_src_b=01, alu_op=00 (rs1+imm latched to ALUOut), then JAL.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (PC ← ALUOut target), then ALUWB, which writes oldPC+4 into rd.
- LUI: result_src=11, reg_write=1, then FETCH.
- TRAP: trap=1, all enables 0, mem_req=0. Absorbing; only reset leaves it.

## Timing
- The state register is the only flop. Outputs are combinational from state; FETCH enables also depend on mem_ready, and BRANCH pc_write on branch_taken.
- While rst=0: state=FETCH, all enables, mem_req and trap forced to 0.
- First mem_req is asserted in the first cycle after rst deasserts.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - R/I-type, JAL, store: 4 cycles
  - load, JALR: 5 cycles
  - branch, LUI: 3 cycles
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Handshake: mem_req, mem_we and adr_src stay stable until the mem_ready cycle. mem_ready sampled while mem_req=0 is ignored.
- Reset asserted mid-instruction aborts it immediately: no partial write enable is asserted after rst falls.

## Structure
- Package `ctrl_pkg`:
  - state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI)
  - mux-code constants for alu_src_a, alu_src_b, alu_op and result_src
- One natural sub-module: `ctrl_out_decode`, purely combinational, mapping state plus mem_ready and branch_taken to the outputs. The FSM next-state logic stays in the top module.

## Test plan
- Reset then R-type add (opcode 0110011), mem_ready tied 1 → states FETCH, DECODE, EXECR, ALUWB; ir_write and pc_write high in cycle 0, reg_write high in cycle 3, back to FETCH in cycle 4.
- Load with 2 wait cycles in FETCH and 1 in MEMREAD → 8 cycles total; adr_src=1 and mem_req held through MEMREAD; reg_write only in MEMWB.
- Branch with branch_taken=1, then the same branch with branch_taken=0 → pc_write pulses once in DECODE+1 only when taken; 3 cycles each.
- JALR → sequence JALR, JAL, ALUWB; pc_write in the JAL state, reg_write in ALUWB, 5 cycles.
- Opcode 0000000 → TRAP; trap=1 and all enables 0 for 20 cycles; rst pulse returns to FETCH with trap=0.
- rst asserted during MEMWRITE with mem_ready=0 → mem_req and mem_we drop in the same cycle; restart in FETCH.
